// File: rtl/mem_access_ctrl.sv
// Two-port (core / loader) access controller in front of a single-port word RAM.
// Round-robin arbitration, RV32I sub-word loads and read-modify-write sub-word stores.
module mem_access_ctrl #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_BITS  = 32,
    parameter int unsigned MEM_WORDS  = 1025
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_BITS-1:0]  core_addr,
    input  logic [2:0]            core_funct3,
    input  logic [DATA_WIDTH-1:0] core_wdata,
    output logic                  core_ack,
    output logic                  core_err,
    output logic [DATA_WIDTH-1:0] core_rdata,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_BITS-1:0]  ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    output logic                  ld_ack,
    output logic                  ld_err,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic [ADDR_BITS-1:0]  ram_addr,
    output logic [DATA_WIDTH-1:0] ram_wd,
    output logic                  ram_we,
    input  logic [DATA_WIDTH-1:0] ram_rd,
    output logic                  busy
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StAccess = 2'd1;
    localparam logic [1:0] StWrite  = 2'd2;
    localparam logic [1:0] StDone   = 2'd3;

    localparam logic [ADDR_BITS-1:0] MemWordsA = ADDR_BITS'(MEM_WORDS);

    logic [1:0]            state_q, state_d;
    logic                  last_ld_q;
    logic                  sel_ld_q;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [1:0]            off_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [ADDR_BITS-1:0]  word_q;
    logic [DATA_WIDTH-1:0] merged_q;
    logic                  core_ack_q, core_err_q, ld_ack_q, ld_err_q;
    logic [DATA_WIDTH-1:0] core_rdata_q, ld_rdata_q;

    // Grant-cycle decode of the winning requester.
    logic                  any_req, grant_ld, g_we, f3_ok, misalign, oor, reject;
    logic [ADDR_BITS-1:0]  g_addr, g_word;
    logic [2:0]            g_f3;
    logic [DATA_WIDTH-1:0] g_wdata;

    always_comb begin
        any_req  = core_req | ld_req;
        grant_ld = ld_req & (~core_req | ~last_ld_q);
        g_we     = grant_ld ? ld_we    : core_we;
        g_addr   = grant_ld ? ld_addr  : core_addr;
        g_wdata  = grant_ld ? ld_wdata : core_wdata;
        g_f3     = grant_ld ? 3'b010   : core_funct3;
        g_word   = g_addr >> 2;
        if (g_we) f3_ok = g_f3 inside {3'b000, 3'b001, 3'b010};
        else      f3_ok = g_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        misalign = ((g_f3[1:0] == 2'b01) && g_addr[0]) ||
                   ((g_f3[1:0] == 2'b10) && (g_addr[1:0] != 2'b00));
        oor      = g_word >= MemWordsA;
        reject   = ~f3_ok | misalign | oor;
    end

    // Load extraction and sub-word merge, both working off the RAM read in ACCESS.
    logic [4:0]            sh;
    logic [DATA_WIDTH-1:0] shifted, load_data, mask, ins, merged_d;
    logic                  st_word, st_sub;

    always_comb begin
        sh      = {off_q, 3'b000};
        shifted = ram_rd >> sh;
        case (f3_q)
            3'b000:  load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
            3'b100:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
            3'b001:  load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
            3'b101:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
            default: load_data = ram_rd;
        endcase
        if (f3_q[1:0] == 2'b00) begin
            mask = DATA_WIDTH'(8'hFF) << sh;
            ins  = DATA_WIDTH'(wdata_q[7:0]) << sh;
        end else begin
            mask = DATA_WIDTH'(16'hFFFF) << sh;
            ins  = DATA_WIDTH'(wdata_q[15:0]) << sh;
        end
        merged_d = (ram_rd & ~mask) | ins;
        st_word  = we_q & (f3_q[1:0] == 2'b10);
        st_sub   = we_q & (f3_q[1:0] != 2'b10);
    end

    // Completion bookkeeping: fin marks the edge that enters DONE.
    logic fin, fin_ld, fin_err, fin_we;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (any_req) state_d = reject ? StDone : StAccess;
            StAccess: state_d = st_sub ? StWrite : StDone;
            StWrite:  state_d = StDone;
            default:  state_d = StIdle;
        endcase
        fin     = (state_d == StDone) && (state_q != StDone);
        fin_err = (state_q == StIdle);
        fin_ld  = (state_q == StIdle) ? grant_ld : sel_ld_q;
        fin_we  = (state_q == StIdle) ? g_we : we_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_ld_q    <= 1'b1;
            sel_ld_q     <= 1'b0;
            we_q         <= 1'b0;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            wdata_q      <= '0;
            word_q       <= '0;
            merged_q     <= '0;
            core_ack_q   <= 1'b0;
            core_err_q   <= 1'b0;
            core_rdata_q <= '0;
            ld_ack_q     <= 1'b0;
            ld_err_q     <= 1'b0;
            ld_rdata_q   <= '0;
        end else begin
            state_q    <= state_d;
            core_ack_q <= 1'b0;
            core_err_q <= 1'b0;
            ld_ack_q   <= 1'b0;
            ld_err_q   <= 1'b0;
            if (state_q == StIdle && any_req) begin
                sel_ld_q  <= grant_ld;
                last_ld_q <= grant_ld;
                we_q      <= g_we;
                f3_q      <= g_f3;
                off_q     <= g_addr[1:0];
                wdata_q   <= g_wdata;
                word_q    <= g_word;
            end
            if (state_q == StAccess && st_sub) merged_q <= merged_d;
            if (fin) begin
                if (fin_ld) begin
                    ld_ack_q <= 1'b1;
                    ld_err_q <= fin_err;
                    if (!fin_we) ld_rdata_q <= fin_err ? '0 : load_data;
                end else begin
                    core_ack_q <= 1'b1;
                    core_err_q <= fin_err;
                    if (!fin_we) core_rdata_q <= fin_err ? '0 : load_data;
                end
            end
        end
    end

    assign core_ack   = core_ack_q;
    assign core_err   = core_err_q;
    assign core_rdata = core_rdata_q;
    assign ld_ack     = ld_ack_q;
    assign ld_err     = ld_err_q;
    assign ld_rdata   = ld_rdata_q;

    // Reset gates the write strobe so an aborted access never lands at the reset edge.
    assign ram_addr = word_q;
    assign ram_we   = ~rst & (((state_q == StAccess) && st_word) || (state_q == StWrite));
    assign ram_wd   = (state_q == StWrite) ? merged_q :
                      ((state_q == StAccess) && st_word) ? wdata_q : '0;
    assign busy     = state_q != StIdle;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed bench for mem_access_ctrl: vector table plus arbitration and reset-abort sequences.
module tb_mem_access_ctrl;

    localparam int MW = 1025;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we;
    logic [31:0] core_addr, core_wdata;
    logic [2:0]  core_funct3;
    logic        core_ack, core_err;
    logic [31:0] core_rdata;
    logic        ld_req, ld_we;
    logic [31:0] ld_addr, ld_wdata;
    logic        ld_ack, ld_err;
    logic [31:0] ld_rdata;
    logic [31:0] ram_addr, ram_wd, ram_rd;
    logic        ram_we;
    logic        busy;

    logic [31:0] mem [0:MW-1];
    logic        tb_wr = 1'b0;
    int          tb_idx = 0;
    logic [31:0] tb_val = 32'h0;

    int n_cmp = 0;
    int n_bad = 0;

    mem_access_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_funct3(core_funct3),
        .core_wdata (core_wdata),
        .core_ack   (core_ack),
        .core_err   (core_err),
        .core_rdata (core_rdata),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ack     (ld_ack),
        .ld_err     (ld_err),
        .ld_rdata   (ld_rdata),
        .ram_addr   (ram_addr),
        .ram_wd     (ram_wd),
        .ram_we     (ram_we),
        .ram_rd     (ram_rd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    assign ram_rd = (ram_addr < 32'(MW)) ? mem[ram_addr[10:0]] : 32'h0;

    always @(posedge clk) begin
        if (ram_we) begin
            if (ram_addr < 32'(MW)) mem[ram_addr[10:0]] <= ram_wd;
        end else if (tb_wr) begin
            mem[tb_idx] <= tb_val;
        end
    end

    typedef struct {
        logic        port;   // 0 = core, 1 = loader
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wdata;
        logic        scr;    // disturb request fields after the grant
        int          pidx;
        logic [31:0] pval;
        int          lat;
        logic        err;
        logic [31:0] rd;
        logic [31:0] mval;   // expected mem[pidx] afterwards
        int          wecnt;
    } tv_t;

    tv_t tv[$];

    function automatic tv_t mk(logic port, logic we, logic [31:0] addr, logic [2:0] f3,
                               logic [31:0] wdata, logic scr, int pidx, logic [31:0] pval,
                               int lat, logic err, logic [31:0] rd, logic [31:0] mval,
                               int wecnt);
        tv_t t;
        t.port = port; t.we = we; t.addr = addr; t.f3 = f3; t.wdata = wdata; t.scr = scr;
        t.pidx = pidx; t.pval = pval; t.lat = lat; t.err = err; t.rd = rd; t.mval = mval;
        t.wecnt = wecnt;
        return t;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        tb_wr = 1'b1; tb_idx = idx; tb_val = val;
        @(posedge clk); #1;
        tb_wr = 1'b0;
    endtask

    task automatic txn(input tv_t v, output int lat, output logic err, output logic [31:0] rd,
                       output int wecnt, output int wecyc, output logic oth,
                       output logic bz1, output logic bz0);
        lat = -1; err = 1'b0; rd = 32'h0; wecnt = 0; wecyc = -1; oth = 1'b0;
        bz1 = 1'b0; bz0 = 1'b1;
        if (!v.port) begin
            core_req = 1'b1; core_we = v.we; core_addr = v.addr;
            core_funct3 = v.f3; core_wdata = v.wdata;
        end else begin
            ld_req = 1'b1; ld_we = v.we; ld_addr = v.addr; ld_wdata = v.wdata;
        end
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            if (k == 1) begin
                bz1 = busy;
                if (v.scr) begin
                    core_we = ~core_we; core_addr = core_addr ^ 32'h10; core_wdata = ~core_wdata;
                    ld_we = ~ld_we; ld_addr = ld_addr ^ 32'h10; ld_wdata = ~ld_wdata;
                end
            end
            if (ram_we) begin wecnt++; wecyc = k; end
            if (v.port ? core_ack : ld_ack) oth = 1'b1;
            if (v.port ? ld_ack : core_ack) begin
                lat = k;
                err = v.port ? ld_err : core_err;
                rd  = v.port ? ld_rdata : core_rdata;
                break;
            end
        end
        core_req = 1'b0; ld_req = 1'b0;
        @(posedge clk); #1;
        bz0 = busy;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int lat, wecnt, wecyc, exp_wecyc;
        logic err, oth, bz1, bz0;
        logic [31:0] rd;
        int acks, nack, both, wide;
        int ack_port[4], ack_cyc[4];
        logic [31:0] ack_rd[4];
        logic prev_c, prev_l;

        rst = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_funct3 = 0; core_wdata = 0;
        ld_req = 0; ld_we = 0; ld_addr = 0; ld_wdata = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("init busy", 32'(busy), 32'd0);

        //          port we addr          f3      wdata         scr pidx pval          lat err rd            mval          wecnt
        tv.push_back(mk(0, 0, 32'h8,    3'b010, 32'h0,        0, 2,   32'hDEADBEEF, 2, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        tv.push_back(mk(0, 1, 32'h9,    3'b000, 32'hAA,       0, 2,   32'h11223344, 3, 0, 32'hDEADBEEF, 32'h1122AA44, 1));
        tv.push_back(mk(0, 0, 32'hA,    3'b001, 32'h0,        0, 2,   32'h80010000, 2, 0, 32'hFFFF8001, 32'h80010000, 0));
        tv.push_back(mk(0, 0, 32'hA,    3'b101, 32'h0,        0, 2,   32'h80010000, 2, 0, 32'h00008001, 32'h80010000, 0));
        tv.push_back(mk(0, 0, 32'h3,    3'b000, 32'h0,        0, 0,   32'h80FF7F01, 2, 0, 32'hFFFFFF80, 32'h80FF7F01, 0));
        tv.push_back(mk(0, 0, 32'h1,    3'b100, 32'h0,        0, 0,   32'h80FF7F01, 2, 0, 32'h0000007F, 32'h80FF7F01, 0));
        tv.push_back(mk(0, 0, 32'h2,    3'b000, 32'h0,        0, 0,   32'h80FF7F01, 2, 0, 32'hFFFFFFFF, 32'h80FF7F01, 0));
        tv.push_back(mk(0, 1, 32'h6,    3'b001, 32'h1234BEEF, 0, 1,   32'hAABBCCDD, 3, 0, 32'hFFFFFFFF, 32'hBEEFCCDD, 1));
        tv.push_back(mk(0, 1, 32'h10,   3'b010, 32'hCAFEF00D, 1, 4,   32'h0,        2, 0, 32'hFFFFFFFF, 32'hCAFEF00D, 1));
        tv.push_back(mk(0, 1, 32'h13,   3'b000, 32'h5A,       0, 4,   32'h0,        3, 0, 32'hFFFFFFFF, 32'h5A000000, 1));
        tv.push_back(mk(0, 0, 32'h6,    3'b010, 32'h0,        0, 1,   32'h55555555, 1, 1, 32'h0,        32'h55555555, 0));
        tv.push_back(mk(0, 0, 32'h8,    3'b011, 32'h0,        0, 2,   32'h12345678, 1, 1, 32'h0,        32'h12345678, 0));
        tv.push_back(mk(0, 0, 32'h8,    3'b010, 32'h0,        0, 2,   32'h12345678, 2, 0, 32'h12345678, 32'h12345678, 0));
        tv.push_back(mk(0, 1, 32'h8,    3'b100, 32'hFFFFFFFF, 0, 2,   32'h12345678, 1, 1, 32'h12345678, 32'h12345678, 0));
        tv.push_back(mk(0, 1, 32'h5,    3'b001, 32'hFFFF,     0, 1,   32'h55555555, 1, 1, 32'h12345678, 32'h55555555, 0));
        tv.push_back(mk(0, 1, 32'h1004, 3'b010, 32'h1,        0, 1024, 32'h77777777, 1, 1, 32'h12345678, 32'h77777777, 0));
        tv.push_back(mk(1, 0, 32'h1004, 3'b010, 32'h0,        0, 1024, 32'h77777777, 1, 1, 32'h0,        32'h77777777, 0));
        tv.push_back(mk(1, 1, 32'h1000, 3'b010, 32'h0BADC0DE, 0, 1024, 32'h0,        2, 0, 32'h0,        32'h0BADC0DE, 1));
        tv.push_back(mk(1, 0, 32'h1000, 3'b010, 32'h0,        0, 1024, 32'h0BADC0DE, 2, 0, 32'h0BADC0DE, 32'h0BADC0DE, 0));
        tv.push_back(mk(1, 0, 32'h2,    3'b010, 32'h0,        0, 0,   32'h80FF7F01, 1, 1, 32'h0,        32'h80FF7F01, 0));
        tv.push_back(mk(1, 0, 32'h0,    3'b010, 32'h0,        0, 0,   32'h80FF7F01, 2, 0, 32'h80FF7F01, 32'h80FF7F01, 0));
        tv.push_back(mk(1, 1, 32'hC,    3'b010, 32'h31415926, 1, 3,   32'h0,        2, 0, 32'h80FF7F01, 32'h31415926, 1));
        tv.push_back(mk(0, 0, 32'h1000, 3'b010, 32'h0,        0, 1024, 32'h0BADC0DE, 2, 0, 32'h0BADC0DE, 32'h0BADC0DE, 0));

        for (int i = 0; i < tv.size(); i++) begin
            preload(tv[i].pidx, tv[i].pval);
            txn(tv[i], lat, err, rd, wecnt, wecyc, oth, bz1, bz0);
            exp_wecyc = (tv[i].wecnt == 1) ? tv[i].lat - 1 : -1;
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(tv[i].lat));
            chk($sformatf("v%0d err", i), 32'(err), 32'(tv[i].err));
            chk($sformatf("v%0d rdata", i), rd, tv[i].rd);
            chk($sformatf("v%0d mem", i), mem[tv[i].pidx], tv[i].mval);
            chk($sformatf("v%0d ram_we count", i), 32'(wecnt), 32'(tv[i].wecnt));
            chk($sformatf("v%0d ram_we cycle", i), 32'(wecyc), 32'(exp_wecyc));
            chk($sformatf("v%0d other ack", i), 32'(oth), 32'd0);
            chk($sformatf("v%0d busy active", i), 32'(bz1), 32'd1);
            chk($sformatf("v%0d busy idle", i), 32'(bz0), 32'd0);
        end

        // Reset during the WRITE cycle of an SH must abort it cleanly.
        preload(1, 32'h13572468);
        core_req = 1'b1; core_we = 1'b1; core_addr = 32'h4;
        core_funct3 = 3'b001; core_wdata = 32'h0000FFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("abort ram_we in WRITE", 32'(ram_we), 32'd1);
        rst = 1'b1; core_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort rdata cleared", core_rdata, 32'h0);
        chk("abort ram_we", 32'(ram_we), 32'd0);
        acks = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (core_ack || ld_ack) acks++;
        end
        chk("abort no ack", 32'(acks), 32'd0);
        chk("abort mem[1]", mem[1], 32'h13572468);

        // Both requesters held from reset: alternate grants, core first.
        preload(2, 32'hA5A5A5A5);
        preload(0, 32'h80FF7F01);
        core_req = 1'b1; core_we = 1'b0; core_addr = 32'h8; core_funct3 = 3'b010;
        ld_req = 1'b1; ld_we = 1'b0; ld_addr = 32'h0;
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("reset core_ack", 32'(core_ack), 32'd0);
        chk("reset core_err", 32'(core_err), 32'd0);
        chk("reset core_rdata", core_rdata, 32'h0);
        chk("reset ld_ack", 32'(ld_ack), 32'd0);
        chk("reset ld_err", 32'(ld_err), 32'd0);
        chk("reset ld_rdata", ld_rdata, 32'h0);
        chk("reset ram_addr", ram_addr, 32'h0);
        chk("reset ram_wd", ram_wd, 32'h0);
        chk("reset ram_we", 32'(ram_we), 32'd0);
        chk("reset busy", 32'(busy), 32'd0);
        nack = 0; both = 0; wide = 0; prev_c = 1'b0; prev_l = 1'b0;
        for (int i = 0; i < 4; i++) begin ack_port[i] = -1; ack_cyc[i] = -1; ack_rd[i] = 0; end
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (core_ack && ld_ack) both++;
            if ((core_ack && prev_c) || (ld_ack && prev_l)) wide++;
            if ((core_ack || ld_ack) && nack < 4) begin
                ack_port[nack] = core_ack ? 0 : 1;
                ack_cyc[nack]  = k;
                ack_rd[nack]   = core_ack ? core_rdata : ld_rdata;
                nack++;
            end
            prev_c = core_ack; prev_l = ld_ack;
            if (nack >= 4) break;
        end
        core_req = 1'b0; ld_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rr ack count", 32'(nack), 32'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("rr%0d port", i), 32'(ack_port[i]), 32'(i % 2));
            chk($sformatf("rr%0d cycle", i), 32'(ack_cyc[i]), 32'(2 + 3 * i));
            chk($sformatf("rr%0d rdata", i), ack_rd[i], (i % 2) ? 32'h80FF7F01 : 32'hA5A5A5A5);
        end
        chk("rr simultaneous acks", 32'(both), 32'd0);
        chk("rr ack width", 32'(wide), 32'd0);
        chk("rr idle busy", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have parameters:
- DATA_WIDTH, 32, data word width.
- ADDR_BITS, 32, requester byte-address width.
- MEM_WORDS, 1025, number of words in the attached data RAM.

REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, single clock; all state updates on posedge.
- rst, in, 1, synchronous active-high reset.
- core_req, in, 1, core request; held with its fields until core_ack.
- core_we, in, 1, 1 = store, 0 = load.
- core_addr, in, ADDR_BITS, byte address.
- core_funct3, in, 3, RV32I width/sign code.
- core_wdata, in, DATA_WIDTH, store data, LSB-aligned.
- core_ack, out, 1, one-cycle completion pulse.
- core_err, out, 1, valid with core_ack; 1 = access rejected.
- core_rdata, out, DATA_WIDTH, load result, valid with core_ack.
- ld_req, in, 1, loader/debug request; word access only.
- ld_we, in, 1, 1 = word store, 0 = word load.
- ld_addr, in, ADDR_BITS, byte address.
- ld_wdata, in, DATA_WIDTH, store word.
- ld_ack, out, 1, one-cycle completion pulse.
- ld_err, out, 1, valid with ld_ack.
- ld_rdata, out, DATA_WIDTH, load word, valid with ld_ack.
- ram_addr, out, ADDR_BITS, RAM word index.
- ram_wd, out, DATA_WIDTH, RAM write data.
- ram_we, out, 1, RAM write enable.
- ram_rd, in, DATA_WIDTH, RAM combinational read data.
- busy, out, 1, high in any state other than IDLE.

Function
REQ-003 SHALL implement the FSM states IDLE, ACCESS, WRITE and DONE, with the state and all outputs registered except ram_* and busy, which SHALL decode from registered state.
REQ-004 In IDLE with any request pending, the block SHALL grant one requester, latch its fields and set ram_addr = addr >> 2; it SHALL go to DONE with err if the access is rejected, else to ACCESS.
REQ-005 Arbitration SHALL be round-robin: a single requester is granted immediately; on a tie, the requester not granted last SHALL win; last_grant SHALL reset to loader, so the core wins the first tie.
REQ-006 A request SHALL be rejected if:
- funct3 is invalid (loads: not 000/001/010/100/101; stores: not 000/001/010), or
- it is misaligned (halfword with addr[0] = 1; word with addr[1:0] != 0), or
- addr >> 2 >= MEM_WORDS.
Loader requests SHALL be checked as word accesses, with funct3 treated as 010.
REQ-007 ACCESS, load: ram_we SHALL be 0; the byte/halfword/word SHALL be selected by addr[1:0]; LB/LH SHALL sign-extend and LBU/LHU SHALL zero-extend; the result SHALL be registered to rdata; next state DONE.
REQ-008 ACCESS, word store: ram_we = 1 and ram_wd = wdata for exactly this one cycle; next state DONE.
REQ-009 ACCESS, sub-word store: ram_we = 0; the merged word SHALL be built from ram_rd by replacing byte addr[1:0] (SB) or halfword addr[1] (SH) with the low bits of wdata; next state WRITE.
REQ-010 WRITE SHALL assert ram_we = 1 with the merged word for exactly one cycle; next state DONE.
REQ-011 DONE SHALL pulse the granted port's ack for one cycle, with err and rdata valid; the other port's ack SHALL stay 0; next state IDLE.
REQ-012 Latency from the grant cycle to ack SHALL be:
- 2 cycles for a load or word store,
- 3 cycles for SB/SH,
- 1 cycle for a rejected access.
REQ-013 rdata SHALL hold its value until the next load completion on that port; rdata SHALL be 0 on a rejected load.
REQ-014 A request that is still asserted in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-015 Changes to the granted requester's fields after the grant SHALL have no effect on the access in progress.
REQ-016 ram_we SHALL never be asserted in IDLE, in DONE, or for a rejected access.

Reset
REQ-017 While rst = 1 at a clock edge, the next state SHALL be IDLE with:
- all acks, errs, rdatas, ram_addr, ram_wd and ram_we = 0,
- busy = 0,
- last_grant = loader.
REQ-018 Reset asserted in ACCESS or WRITE SHALL abort the access: no ack SHALL be issued, and no RAM write SHALL occur after the reset edge.

Verification
REQ-019 After reset, mem[2] = 0xDEADBEEF, core LW to 0x8 -> core_ack 2 cycles after grant, core_rdata = 0xDEADBEEF, core_err = 0.
REQ-020 mem[2] = 0x11223344, core SB to 0x9 with wdata 0xAA -> ram_we high only in WRITE, mem[2] = 0x1122AA44, ack 3 cycles after grant.
REQ-021 mem[2] = 0x80010000, LH to 0xA -> rdata 0xFFFF8001; LHU to 0xA -> rdata 0x00008001.
REQ-022 core_req and ld_req held high continuously from reset -> grant order core, loader, core, loader; each ack a single-cycle pulse.
REQ-023 Each of the following -> err = 1 with ack 1 cycle after grant, ram_we never asserted, memory unchanged:
- core LW to 0x6,
- funct3 011,
- loader access to word index MEM_WORDS.
REQ-024 rst pulsed during WRITE of SH to 0x4 -> mem[1] unchanged, no core_ack, busy = 0 on the cycle after the reset edge.
